// File: rtl/mux_scan_seq_if.sv
// Channel bank / consumer bundle for mux_scan_seq.
// Latency: none, wires only.
// Backpressure: none; out_valid qualifies out/out_ch for a single cycle.
// Ports: master drives in_bus/sel/mode/ch_en/start and observes the results;
//        slave is the multiplexer side (out, out_ch, out_valid, busy, sweep_done).
interface mux_scan_seq_if #(
    parameter int N_CH   = 16,
    parameter int DATA_W = 1,
    parameter int SEL_W  = 4
);
    logic [N_CH*DATA_W-1:0] in_bus;
    logic [SEL_W-1:0]       sel;
    logic                   mode;
    logic [N_CH-1:0]        ch_en;
    logic                   start;
    logic [DATA_W-1:0]      out;
    logic [SEL_W-1:0]       out_ch;
    logic                   out_valid;
    logic                   busy;
    logic                   sweep_done;

    modport master (
        output in_bus, sel, mode, ch_en, start,
        input  out, out_ch, out_valid, busy, sweep_done
    );

    modport slave (
        input  in_bus, sel, mode, ch_en, start,
        output out, out_ch, out_valid, busy, sweep_done
    );
endinterface

// File: rtl/mux_scan_seq.sv
// N_CH x DATA_W channel multiplexer: manual registered select or masked scan sweep.
// Latency: 1 cycle in manual mode; first scan result DWELL cycles after the start edge.
// Backpressure: none; the consumer must take each out_valid beat as it comes.
// Ports: clk, rst (sync, active-high), bus (mux_scan_seq_if.slave).
// Optional build macro MUX_SCAN_CONT_EN: continuous scanning, wrapping to the lowest
// enabled channel after the last one instead of ending the sweep.
module mux_scan_seq #(
    parameter int N_CH   = 16,
    parameter int DATA_W = 1,
    parameter int SEL_W  = 4,
    parameter int DWELL  = 1
) (
    input logic         clk,
    input logic         rst,
    mux_scan_seq_if.slave bus
);
    localparam int DW_W = (DWELL > 1) ? $clog2(DWELL) : 1;

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    state_t            state_q, state_n;
    logic [N_CH-1:0]   mask_q, mask_n;
    logic [SEL_W-1:0]  cur_ch_q, cur_ch_n;
    logic [DW_W-1:0]   dwell_q, dwell_n;
    logic [DATA_W-1:0] out_q, out_n;
    logic [SEL_W-1:0]  out_ch_q, out_ch_n;
    logic              valid_q, valid_n;
    logic              busy_q, busy_n;
    logic              done_q, done_n;
    logic [SEL_W:0]    fs;
`ifdef MUX_SCAN_CONT_EN
    // Set when the end-of-sweep pulse already went out at the wrap point, so
    // the trailing DONE state must stay quiet.
    logic              wrapped_q, wrapped_n;
    logic [SEL_W:0]    fw;
`endif

    // Channel slice by index; out-of-range indices read as zero.
    function automatic logic [DATA_W-1:0] slice(input logic [N_CH*DATA_W-1:0] b,
                                                input logic [SEL_W-1:0] idx);
        slice = '0;
        for (int k = 0; k < N_CH; k++)
            if (int'(idx) == k) slice = b[k*DATA_W +: DATA_W];
    endfunction

    // Lowest set mask bit at or above 'from'; MSB of the result flags found.
    function automatic logic [SEL_W:0] first_set(input logic [N_CH-1:0] m, input int from);
        first_set = '0;
        for (int k = N_CH - 1; k >= 0; k--)
            if (m[k] && k >= from) first_set = {1'b1, SEL_W'(k)};
    endfunction

    always_comb begin
        state_n  = state_q;
        mask_n   = mask_q;
        cur_ch_n = cur_ch_q;
        dwell_n  = dwell_q;
        out_n    = out_q;
        out_ch_n = out_ch_q;
        valid_n  = 1'b0;
        busy_n   = busy_q;
        done_n   = 1'b0;
        fs       = '0;
`ifdef MUX_SCAN_CONT_EN
        wrapped_n = wrapped_q;
        fw        = '0;
`endif
        unique case (state_q)
            IDLE: begin
                busy_n = 1'b0;
                if (!bus.mode) begin
                    out_ch_n = bus.sel;
                    out_n    = slice(bus.in_bus, bus.sel);
                    valid_n  = (int'(bus.sel) < N_CH);
                end else if (bus.start) begin
                    mask_n  = bus.ch_en;
                    dwell_n = '0;
                    fs      = first_set(bus.ch_en, 0);
                    if (fs[SEL_W]) begin
                        state_n  = SCAN;
                        cur_ch_n = fs[SEL_W-1:0];
                        busy_n   = 1'b1;
                    end else begin
                        state_n = DONE;
                    end
                end
            end
            SCAN: begin
                if (int'(dwell_q) != DWELL - 1) begin
                    dwell_n = dwell_q + 1'b1;
                end else begin
                    dwell_n  = '0;
                    out_n    = slice(bus.in_bus, cur_ch_q);
                    out_ch_n = cur_ch_q;
                    valid_n  = 1'b1;
                    fs       = first_set(mask_q, int'(cur_ch_q) + 1);
                    if (fs[SEL_W]) begin
                        cur_ch_n = fs[SEL_W-1:0];
                    end else begin
`ifdef MUX_SCAN_CONT_EN
                        // End of a pass: report it now and re-sample mode/mask.
                        done_n = 1'b1;
                        fw     = first_set(bus.ch_en, 0);
                        if (bus.mode && fw[SEL_W]) begin
                            mask_n   = bus.ch_en;
                            cur_ch_n = fw[SEL_W-1:0];
                        end else begin
                            state_n   = DONE;
                            wrapped_n = 1'b1;
                        end
`else
                        state_n = DONE;
`endif
                    end
                end
            end
            DONE: begin
                state_n = IDLE;
                busy_n  = 1'b0;
`ifdef MUX_SCAN_CONT_EN
                done_n    = !wrapped_q;
                wrapped_n = 1'b0;
`else
                done_n  = 1'b1;
`endif
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            mask_q   <= '0;
            cur_ch_q <= '0;
            dwell_q  <= '0;
            out_q    <= '0;
            out_ch_q <= '0;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
`ifdef MUX_SCAN_CONT_EN
            wrapped_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_n;
            mask_q   <= mask_n;
            cur_ch_q <= cur_ch_n;
            dwell_q  <= dwell_n;
            out_q    <= out_n;
            out_ch_q <= out_ch_n;
            valid_q  <= valid_n;
            busy_q   <= busy_n;
            done_q   <= done_n;
`ifdef MUX_SCAN_CONT_EN
            wrapped_q <= wrapped_n;
`endif
        end
    end

    assign bus.out        = out_q;
    assign bus.out_ch     = out_ch_q;
    assign bus.out_valid  = valid_q;
    assign bus.busy       = busy_q;
    assign bus.sweep_done = done_q;
endmodule
